// File: rtl/nano_dbg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nano_dbg_pkg : command codes and FSM state encoding for the debug SPI port
// Rev 1.0
// ----------------------------------------------------------------------------
package nano_dbg_pkg;

    localparam logic [7:0] c_cmd_write = 8'h01;
    localparam logic [7:0] c_cmd_read  = 8'h02;
    localparam logic [7:0] c_cmd_halt  = 8'h03;
    localparam logic [7:0] c_cmd_run   = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_WDATA   = 3'd4,
        ST_RDATA   = 3'd5,
        ST_IGNORE  = 3'd6
    } dbg_state_e;

endpackage
`default_nettype wire

// File: rtl/nano_dbg_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nano_dbg_sync : multi-flop synchronizer with rise/fall detection
// Rev 1.0
// ----------------------------------------------------------------------------
module nano_dbg_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Flops preload the idle level so reset release never looks like an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_async};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign o_sync = sync_q[STAGES-1];
    assign o_rise = sync_q[STAGES-1] & ~prev_q;
    assign o_fall = ~sync_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/nano_dbg_spi_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nano_dbg_spi_ctrl : SPI-slave debug port giving memory access and core halt
// Rev 1.0
// ----------------------------------------------------------------------------
module nano_dbg_spi_ctrl
    import nano_dbg_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_nano_clk,
    input  logic              i_nano_rst_n,
    input  logic              i_dbg_spi_en_n,
    input  logic              i_dbg_spi_sclk,
    input  logic              i_dbg_spi_mosi,
    output logic              o_dbg_spi_miso,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_core_halt
);

    logic w_en_lvl, w_en_rise, w_en_fall;
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;

    nano_dbg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
        .i_clk(i_nano_clk), .i_rst_n(i_nano_rst_n), .i_async(i_dbg_spi_en_n),
        .o_sync(w_en_lvl), .o_rise(w_en_rise), .o_fall(w_en_fall)
    );

    nano_dbg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_nano_clk), .i_rst_n(i_nano_rst_n), .i_async(i_dbg_spi_sclk),
        .o_sync(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    nano_dbg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_nano_clk), .i_rst_n(i_nano_rst_n), .i_async(i_dbg_spi_mosi),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    dbg_state_e        state_q;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        shift_q;
    logic [7:0]        addr_hi_q;
    logic              wr_cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              we_q;
    logic              re_q;
    logic              halt_q;
    logic [7:0]        tx_q;
    logic              miso_q;
    logic              rd_pend_q;
    logic              ld_q;

    logic [7:0]  w_byte;
    logic [15:0] w_addr16;
    logic        w_last;

    assign w_byte   = {shift_q, w_mosi};
    assign w_addr16 = {addr_hi_q, w_byte};
    assign w_last   = (bit_cnt_q == 3'd7);

    always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
        if (!i_nano_rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_hi_q <= '0;
            wr_cmd_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            halt_q    <= 1'b0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            ld_q      <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            // Read data arrives one cycle after the strobe, so load a cycle later still.
            ld_q      <= rd_pend_q;
            if (we_q || re_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (w_en_rise) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                ld_q      <= 1'b0;
                tx_q      <= '0;
                miso_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_en_fall) begin
                            state_q   <= ST_CMD;
                            bit_cnt_q <= '0;
                            shift_q   <= '0;
                        end
                    end
                    ST_RDATA: begin
                        if (w_sclk_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                        if (ld_q) begin
                            tx_q <= halt_q ? i_mem_rdata : 8'h00;
                        end
                        if (w_sclk_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (w_last) begin
                                re_q      <= halt_q;
                                rd_pend_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (w_sclk_rise) begin
                            shift_q   <= w_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (w_last) begin
                                case (state_q)
                                    ST_CMD: begin
                                        if (w_byte == c_cmd_write || w_byte == c_cmd_read) begin
                                            wr_cmd_q <= (w_byte == c_cmd_write);
                                            state_q  <= ST_ADDR_HI;
                                        end else begin
                                            if (w_byte == c_cmd_halt) begin
                                                halt_q <= 1'b1;
                                            end else if (w_byte == c_cmd_run) begin
                                                halt_q <= 1'b0;
                                            end
                                            state_q <= ST_IGNORE;
                                        end
                                    end
                                    ST_ADDR_HI: begin
                                        addr_hi_q <= w_byte;
                                        state_q   <= ST_ADDR_LO;
                                    end
                                    ST_ADDR_LO: begin
                                        addr_q <= w_addr16[ADDR_W-1:0];
                                        if (wr_cmd_q) begin
                                            state_q <= ST_WDATA;
                                        end else begin
                                            state_q   <= ST_RDATA;
                                            re_q      <= halt_q;
                                            rd_pend_q <= 1'b1;
                                        end
                                    end
                                    ST_WDATA: begin
                                        wdata_q <= w_byte;
                                        we_q    <= halt_q;
                                    end
                                    default: begin
                                    end
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign o_dbg_spi_miso = miso_q;
    assign o_mem_addr     = addr_q;
    assign o_mem_wdata    = wdata_q;
    assign o_mem_we       = we_q;
    assign o_mem_re       = re_q;
    assign o_core_halt    = halt_q;

    logic unused_sync;
    assign unused_sync = ^{w_en_lvl, w_sclk_lvl, w_mosi_rise, w_mosi_fall, w_addr16};

endmodule
`default_nettype wire

// File: doc/nano_dbg_spi_ctrl.md
NANO_DBG_SPI_CTRL -- requirements
Module: nano_dbg_spi_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory word-address width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for SPI inputs (min 2).
REQ-003 SHALL have port i_nano_clk, input, 1, single system clock; all logic in this domain.
REQ-004 SHALL have port i_nano_rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port i_dbg_spi_en_n, input, 1, SPI chip select, active-low, asynchronous to clock.
REQ-006 SHALL have port i_dbg_spi_sclk, input, 1, SPI clock, mode 0, asynchronous.
REQ-007 SHALL have port i_dbg_spi_mosi, input, 1, SPI serial data in, MSB first.
REQ-008 SHALL have port o_dbg_spi_miso, output, 1, SPI serial data out, MSB first.
REQ-009 SHALL have port o_mem_addr, output, ADDR_W, program/data memory address.
REQ-010 SHALL have port o_mem_wdata, output, 8, memory write data.
REQ-011 SHALL have ports o_mem_we and o_mem_re, outputs, 1 each, single-cycle access strobes.
REQ-012 SHALL have port i_mem_rdata, input, 8, read data valid one cycle after o_mem_re.
REQ-013 SHALL have port o_core_halt, output, 1, stalls NanoController core while high.

Function
REQ-014 SHALL oversample sclk, mosi, en_n through SYNC_STAGES flops; sclk edges from synchronized value.
REQ-015 SHALL sample mosi on synchronized sclk rising edge, update miso on falling edge.
REQ-016 SHALL require sclk high and low phases each >= 4 i_nano_clk cycles; faster sclk is unsupported.
REQ-017 SHALL frame: 8-bit command, 16-bit address (MSB first, low ADDR_W bits used), then data bytes.
REQ-018 SHALL decode commands: 0x01 WRITE, 0x02 READ, 0x03 HALT, 0x04 RUN; others -> IGNORE until en_n high.
REQ-019 SHALL use FSM states IDLE, CMD, ADDR_HI, ADDR_LO, WDATA, RDATA, IGNORE.
REQ-020 SHALL go IDLE->CMD on synchronized en_n falling; CMD->ADDR_HI after 8 bits for WRITE/READ.
REQ-021 SHALL set o_core_halt 1 (HALT) or 0 (RUN) one cycle after 8th command bit; next state IGNORE.
REQ-022 SHALL go ADDR_HI->ADDR_LO->WDATA or RDATA, 8 bits each.
REQ-023 SHALL in WDATA pulse o_mem_we one cycle per full byte, then increment address; burst continues.
REQ-024 SHALL in RDATA pulse o_mem_re at state entry and after each shifted-out byte, loading miso shifter one cycle later, before next falling edge.
REQ-025 SHALL wrap address from 2^ADDR_W-1 to 0 in bursts.
REQ-026 SHALL suppress o_mem_we/o_mem_re while o_core_halt is 0; WRITE/READ then discarded (READ returns 0x00).
REQ-027 SHALL abort to IDLE on en_n rising in any state; partial byte never written; o_core_halt unchanged.
REQ-028 SHALL drive o_dbg_spi_miso 0 outside RDATA.
REQ-029 SHALL reset bit counter on each en_n falling edge.

Reset
REQ-030 SHALL reset asynchronously: FSM IDLE, shifters/counters 0, o_mem_addr 0, o_mem_wdata 0, o_mem_we 0, o_mem_re 0, o_dbg_spi_miso 0, o_core_halt 0.
REQ-031 SHALL preload synchronizer flops with idle levels (en_n 1, sclk 0, mosi 0).
REQ-032 SHALL emit no memory strobe within SYNC_STAGES+1 cycles after reset release.

Structure
REQ-033 SHALL place command codes and FSM state enum in shared package nano_dbg_pkg.
REQ-034 SHALL instantiate sub-module nano_dbg_sync (parameterized synchronizer with rise/fall detect) per SPI input.

Verification
REQ-035 SHALL test HALT then WRITE addr 0x0005 data 0xA5,0x3C -> o_core_halt=1; we pulses addr 5 0xA5, addr 6 0x3C.
REQ-036 SHALL test READ addr 0x03FF with memory 0x3FF=0x11, 0x000=0x22 -> miso 0x11 then 0x22 (wrap).
REQ-037 SHALL test WRITE with core running (halt=0) -> zero o_mem_we pulses; READ returns 0x00.
REQ-038 SHALL test en_n rising after 5 bits of data byte -> no o_mem_we, FSM IDLE, next frame decodes correctly.
REQ-039 SHALL test command 0x7F followed by 24 bits -> no strobes, halt unchanged, miso 0.
REQ-040 SHALL test reset asserted mid-WDATA -> all outputs reset values immediately, including o_core_halt=0.
